uart_tx_fifo: RTL

//   Parametrised UART transmitter with integrated TX FIFO; successor to the fixed 8N1 uart_tx.

---
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an integrated TX FIFO. Words written on the valid/ready
//   port are buffered and sent back-to-back on the serial line. Each frame is one
//   start bit, DATA_BITS data bits (LSB first), an optional parity bit and
//   STOP_BITS stop bits. Every bit lasts CLK_DIV clocks.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | line high; pop the FIFO head as soon as the FIFO is non-empty
//   ST_START | start bit (low)
//   ST_DATA  | data bits, LSB first; bit_idx selects the bit
//   ST_PARITY| parity bit; this state is never entered when PARITY = 0
//   ST_STOP  | stop bit(s), high; the last cycle may pop and restart directly
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_data        word to transmit, sampled only on an accepted write
//   i_valid       i_data valid
//   o_ready       FIFO can accept a word (not full)
//   o_uart_tx     serial line, idle high, driven from a flop
//   o_busy        frame in progress or FIFO non-empty (registered)
//   o_fifo_count  number of words held in the FIFO
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count, count_n;
  logic                 push, pop;

  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 baud_last;
  logic                 tx_n, busy_n;

  assign o_ready      = (count != FULL);
  assign o_fifo_count = count;
  assign baud_last    = (baud_cnt == BAUD_LAST);

  // A write is judged against the pre-edge count, so a full FIFO refuses it
  // even when a pop happens in the same cycle.
  assign push = i_valid && o_ready;

  // Pop while idle, or on the final stop-bit cycle so the next start bit
  // follows without an idle gap.
  assign pop = (count != '0) &&
               ((state == ST_IDLE) ||
                ((state == ST_STOP) && baud_last && (bit_idx == STOP_LAST)));

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + (AW + 1)'(1);
      2'b01:   count_n = count - (AW + 1)'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem[wr_ptr] <= i_data;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (pop) state_n = ST_START;
      ST_START:  if (baud_last) state_n = ST_DATA;
      ST_DATA:   if (baud_last && (bit_idx == DATA_LAST))
                   state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_last) state_n = ST_STOP;
      ST_STOP:   if (baud_last && (bit_idx == STOP_LAST))
                   state_n = pop ? ST_START : ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Output logic, registered below so the line never glitches
  always_comb begin
    tx_n = 1'b1;
    case (state)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_reg[0];
      ST_PARITY: tx_n = par_bit;
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != ST_IDLE) || (count_n != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      o_uart_tx <= tx_n;
      o_busy    <= busy_n;

      if ((state == ST_IDLE) || baud_last) baud_cnt <= '0;
      else                                 baud_cnt <= baud_cnt + CW'(1);

      // bit_idx counts data bits in ST_DATA and stop bits in ST_STOP
      if (state_n != state)
        bit_idx <= '0;
      else if (baud_last && ((state == ST_DATA) || (state == ST_STOP)))
        bit_idx <= bit_idx + BW'(1);

      // Parity is taken from the whole word at load time, before shifting
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        par_bit   <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
      end else if ((state == ST_DATA) && baud_last) begin
        shift_reg <= shift_reg >> 1;
      end
    end
  end

endmodule
